// File: rtl/canv_layer_agu.sv
// canv_layer_agu: multi-layer canvas address generator. Produces a VRAM word address, pixel ID and paint flag per layer.
// Latency: paint 1 cycle after dx; addr/pix_id 2 cycles after the dx cycle that requested a VRAM read.
// Backpressure: none; free-running at the pixel clock, one result per layer per cycle.
// Ports: clk_pix/rst_pix pixel clock and sync active-high reset; frame_start/line_start/dx/dy display timing;
//        layer_en plus per-layer config buses (layer L uses slice [L*W +: W]); addr/pix_id/paint per-layer outputs.
module canv_layer_agu #(
  parameter int CORDW    = 16,
  parameter int WORD     = 32,
  parameter int ADDRW    = 20,
  parameter int LAYERS   = 2,
  parameter int BMAP_LAT = 4,
  parameter int PIX_IDW  = $clog2(WORD),
  parameter int SHIFTW   = 3,
  parameter int PADW     = ADDRW + PIX_IDW
) (
  input  logic                        clk_pix,
  input  logic                        rst_pix,
  input  logic                        frame_start,
  input  logic                        line_start,
  input  logic signed [CORDW-1:0]     dx,
  input  logic signed [CORDW-1:0]     dy,
  input  logic [LAYERS-1:0]           layer_en,
  input  logic [LAYERS*ADDRW-1:0]     addr_base,
  input  logic [LAYERS*SHIFTW-1:0]    addr_shift,
  input  logic [LAYERS*PADW-1:0]      stride,
  input  logic [LAYERS*PADW-1:0]      offset,
  input  logic [LAYERS*2*CORDW-1:0]   win_start,
  input  logic [LAYERS*2*CORDW-1:0]   win_end,
  input  logic [LAYERS*2*CORDW-1:0]   scale,
  output logic [LAYERS*ADDRW-1:0]     addr,
  output logic [LAYERS*PIX_IDW-1:0]   pix_id,
  output logic [LAYERS-1:0]           paint
);

  // Horizontal window tests run two bits wider so start-BMAP_LAT and
  // start-1 cannot overflow near the bottom of the coordinate range.
  localparam int CW = CORDW + 2;
  localparam logic signed [CW-1:0] ONE_W = CW'(1);
  localparam logic signed [CW-1:0] LAT_W = CW'(BMAP_LAT);

  logic signed [CW-1:0] dx_w;
  assign dx_w = CW'(dx);

  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    // Shadow configuration, held constant for a whole frame
    logic                    en_q;
    logic [ADDRW-1:0]        base_q;
    logic [SHIFTW-1:0]       shift_q;
    logic [PADW-1:0]         stride_q;
    logic signed [CORDW-1:0] sx_q, sy_q, ex_q, ey_q;
    logic [CORDW-1:0]        scx_q, scy_q;

    // Stage 1 state
    logic [CORDW-1:0]        cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    logic [PADW-1:0]         ln_pix_q, ln_pix_d, addr_pix_q, addr_pix_d;
    logic                    paint_q, paint_d, vram_read_q, vram_read_d;

    // Stage 2 state
    logic [ADDRW-1:0]        addr_q, addr_d;
    logic [PIX_IDW-1:0]      pix_id_q, pix_id_d, pix_mask;

    logic signed [CW-1:0]    sx_w, ex_w;
    logic                    win_y;
    logic [CORDW-1:0]        scx_m1, scy_m1;

    assign sx_w  = CW'(sx_q);
    assign ex_w  = CW'(ex_q);
    assign win_y = (dy >= sy_q) && (dy < ey_q);

    // paint is registered, so the test is one pixel early; vram_read runs
    // BMAP_LAT early so fetched data lines up with the paint window.
    assign paint_d     = en_q && win_y && (dx_w >= sx_w - ONE_W) && (dx_w < ex_w - ONE_W);
    assign vram_read_d = en_q && win_y && (dx_w >= sx_w - LAT_W) && (dx_w < ex_w - LAT_W);

    // A scale of 0 behaves as 1
    assign scx_m1 = (scx_q == '0) ? '0 : scx_q - CORDW'(1);
    assign scy_m1 = (scy_q == '0) ? '0 : scy_q - CORDW'(1);

    always_comb begin
      cnt_x_d    = cnt_x_q;
      cnt_y_d    = cnt_y_q;
      ln_pix_d   = ln_pix_q;
      addr_pix_d = addr_pix_q;
      if (frame_start) begin
        // Load from the incoming offset so the new frame scrolls immediately
        cnt_x_d    = '0;
        cnt_y_d    = '0;
        ln_pix_d   = offset[l*PADW +: PADW];
        addr_pix_d = offset[l*PADW +: PADW];
      end else if (en_q && line_start && (dy > sy_q)) begin
        cnt_x_d = '0;
        if (cnt_y_q == scy_m1) begin
          cnt_y_d    = '0;
          ln_pix_d   = ln_pix_q + stride_q;
          addr_pix_d = ln_pix_q + stride_q;
        end else begin
          // Vertical scaling: replay the same canvas line
          cnt_y_d    = cnt_y_q + CORDW'(1);
          addr_pix_d = ln_pix_q;
        end
      end else if (vram_read_q) begin
        if (cnt_x_q == scx_m1) begin
          cnt_x_d    = '0;
          addr_pix_d = addr_pix_q + PADW'(1);
        end else begin
          cnt_x_d = cnt_x_q + CORDW'(1);
        end
      end
    end

    assign pix_mask = PIX_IDW'((32'd1 << shift_q) - 32'd1);
    assign addr_d   = base_q + ADDRW'(addr_pix_q >> shift_q);
    assign pix_id_d = addr_pix_q[PIX_IDW-1:0] & pix_mask;

    always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
        en_q        <= 1'b0;
        base_q      <= '0;
        shift_q     <= '0;
        stride_q    <= '0;
        sx_q        <= '0;
        sy_q        <= '0;
        ex_q        <= '0;
        ey_q        <= '0;
        scx_q       <= '0;
        scy_q       <= '0;
        cnt_x_q     <= '0;
        cnt_y_q     <= '0;
        ln_pix_q    <= '0;
        addr_pix_q  <= '0;
        paint_q     <= 1'b0;
        vram_read_q <= 1'b0;
        addr_q      <= '0;
        pix_id_q    <= '0;
      end else begin
        if (frame_start) begin
          en_q     <= layer_en[l];
          base_q   <= addr_base[l*ADDRW +: ADDRW];
          shift_q  <= addr_shift[l*SHIFTW +: SHIFTW];
          stride_q <= stride[l*PADW +: PADW];
          sx_q     <= win_start[l*2*CORDW +: CORDW];
          sy_q     <= win_start[l*2*CORDW + CORDW +: CORDW];
          ex_q     <= win_end[l*2*CORDW +: CORDW];
          ey_q     <= win_end[l*2*CORDW + CORDW +: CORDW];
          scx_q    <= scale[l*2*CORDW +: CORDW];
          scy_q    <= scale[l*2*CORDW + CORDW +: CORDW];
        end
        cnt_x_q     <= cnt_x_d;
        cnt_y_q     <= cnt_y_d;
        ln_pix_q    <= ln_pix_d;
        addr_pix_q  <= addr_pix_d;
        paint_q     <= paint_d;
        vram_read_q <= vram_read_d;
        addr_q      <= addr_d;
        pix_id_q    <= pix_id_d;
      end
    end

    assign addr[l*ADDRW +: ADDRW]       = addr_q;
    assign pix_id[l*PIX_IDW +: PIX_IDW] = pix_id_q;
    assign paint[l]                     = paint_q;
  end

endmodule

// File: tb/tb_canv_layer_agu.sv
module tb_canv_layer_agu;
  localparam int CORDW   = 16;
  localparam int ADDRW   = 20;
  localparam int NL      = 2;
  localparam int LAT     = 4;
  localparam int PIX_IDW = 5;
  localparam int SHIFTW  = 3;
  localparam int PADW    = 25;
  localparam int XLO     = -8;
  localparam int XHI     = 9;
  localparam int NONE    = 1000;

  logic                     clk_pix = 1'b0;
  logic                     rst_pix, frame_start, line_start;
  logic signed [CORDW-1:0]  dx, dy;
  logic [NL-1:0]            c_en;
  logic [NL*ADDRW-1:0]      addr_base;
  logic [NL*SHIFTW-1:0]     addr_shift;
  logic [NL*PADW-1:0]       stride, offset;
  logic [NL*2*CORDW-1:0]    win_start, win_end, scale;
  logic [NL*ADDRW-1:0]      addr;
  logic [NL*PIX_IDW-1:0]    pix_id;
  logic [NL-1:0]            paint;

  always #5 clk_pix = ~clk_pix;

  canv_layer_agu #(
    .CORDW(CORDW), .WORD(32), .ADDRW(ADDRW), .LAYERS(NL), .BMAP_LAT(LAT),
    .PIX_IDW(PIX_IDW), .SHIFTW(SHIFTW), .PADW(PADW)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame_start(frame_start), .line_start(line_start),
    .dx(dx), .dy(dy), .layer_en(c_en), .addr_base(addr_base), .addr_shift(addr_shift),
    .stride(stride), .offset(offset), .win_start(win_start), .win_end(win_end), .scale(scale),
    .addr(addr), .pix_id(pix_id), .paint(paint)
  );

  typedef struct { int due; int kind; int layer; int x; int y; int val; } exp_t;
  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;

  // Config driven to the DUT and the bench's own frame-shadowed copy
  int c_base[NL], c_shift[NL], c_stride[NL], c_off[NL];
  int c_sx[NL], c_sy[NL], c_ex[NL], c_ey[NL], c_scx[NL], c_scy[NL];
  int m_base[NL], m_shift[NL], m_stride[NL], m_off[NL];
  int m_sx[NL], m_sy[NL], m_ex[NL], m_ey[NL], m_scx[NL], m_scy[NL];
  logic [NL-1:0] m_en;

  always_comb begin
    addr_base = '0; addr_shift = '0; stride = '0; offset = '0;
    win_start = '0; win_end = '0; scale = '0;
    for (int l = 0; l < NL; l++) begin
      addr_base[l*ADDRW +: ADDRW]            = c_base[l][ADDRW-1:0];
      addr_shift[l*SHIFTW +: SHIFTW]         = c_shift[l][SHIFTW-1:0];
      stride[l*PADW +: PADW]                 = c_stride[l][PADW-1:0];
      offset[l*PADW +: PADW]                 = c_off[l][PADW-1:0];
      win_start[l*2*CORDW +: CORDW]          = c_sx[l][CORDW-1:0];
      win_start[l*2*CORDW + CORDW +: CORDW]  = c_sy[l][CORDW-1:0];
      win_end[l*2*CORDW +: CORDW]            = c_ex[l][CORDW-1:0];
      win_end[l*2*CORDW + CORDW +: CORDW]    = c_ey[l][CORDW-1:0];
      scale[l*2*CORDW +: CORDW]              = c_scx[l][CORDW-1:0];
      scale[l*2*CORDW + CORDW +: CORDW]      = c_scy[l][CORDW-1:0];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push(input int due, input int kind, input int l, input int x, input int y, input int val);
    exp_t e;
    e.due = due; e.kind = kind; e.layer = l; e.x = x; e.y = y; e.val = val;
    exp_q.push_back(e);
  endfunction

  // One clock edge, then compare every expectation that falls due on it
  task automatic tick();
    exp_t e;
    logic [31:0] got;
    string nm;
    int i;
    @(posedge clk_pix);
    edges++;
    #1;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].due <= edges) begin
        e = exp_q[i];
        exp_q.delete(i);
        case (e.kind)
          0:       begin got = 32'(paint[e.layer]);                     nm = "paint";  end
          1:       begin got = 32'(addr[e.layer*ADDRW +: ADDRW]);       nm = "addr";   end
          default: begin got = 32'(pix_id[e.layer*PIX_IDW +: PIX_IDW]); nm = "pix_id"; end
        endcase
        check_eq($sformatf("L%0d %s dx=%0d dy=%0d", e.layer, nm, e.x, e.y), got, e.val);
      end else begin
        i++;
      end
    end
  endtask

  task automatic drive(input int x, input int y, input bit fs, input bit ls, input bit rst);
    dx = CORDW'(x); dy = CORDW'(y);
    frame_start = fs; line_start = ls; rst_pix = rst;
    if (rst) begin
      exp_q.delete();
      m_en = '0;
      m_base = '{default: 0}; m_shift = '{default: 0}; m_stride = '{default: 0};
      m_off = '{default: 0};  m_sx = '{default: 0};    m_sy = '{default: 0};
      m_ex = '{default: 0};   m_ey = '{default: 0};    m_scx = '{default: 0};
      m_scy = '{default: 0};
      for (int l = 0; l < NL; l++) begin
        push(edges + 1, 0, l, x, y, 0);
        push(edges + 1, 1, l, x, y, 0);
        push(edges + 1, 2, l, x, y, 0);
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        bit wy, pt, rd;
        int scx, scy, k, ly;
        longint ap;
        wy = (y >= m_sy[l]) && (y < m_ey[l]);
        pt = m_en[l] && wy && (x >= m_sx[l] - 1) && (x < m_ex[l] - 1);
        rd = m_en[l] && wy && (x >= m_sx[l] - LAT) && (x < m_ex[l] - LAT);
        push(edges + 1, 0, l, x, y, int'(pt));
        if (rd) begin
          scx = (m_scx[l] == 0) ? 1 : m_scx[l];
          scy = (m_scy[l] == 0) ? 1 : m_scy[l];
          k   = x - (m_sx[l] - LAT);
          ly  = (y - m_sy[l]) / scy;
          ap  = (longint'(m_off[l]) + longint'(ly) * longint'(m_stride[l]) + longint'(k / scx))
                & ((64'd1 << PADW) - 1);
          push(edges + 2, 1, l, x, y, int'((longint'(m_base[l]) + (ap >> m_shift[l])) & 64'hFFFFF));
          push(edges + 2, 2, l, x, y, int'(ap & longint'((1 << m_shift[l]) - 1) & 64'd31));
        end
      end
      if (fs) begin
        m_en = c_en;
        m_base = c_base; m_shift = c_shift; m_stride = c_stride; m_off = c_off;
        m_sx = c_sx; m_sy = c_sy; m_ex = c_ex; m_ey = c_ey; m_scx = c_scx; m_scy = c_scy;
      end
    end
    tick();
  endtask

  // One display line; line_start on its first pixel, optional frame_start there too
  task automatic run_line(input int y, input bit fs, input int rst_x);
    for (int x = XLO; x <= XHI; x++)
      drive(x, y, fs && (x == XLO), x == XLO, x == rst_x);
  endtask

  task automatic set_layer(input int l, input int base, input int sh, input int str, input int off,
                           input int sx, input int sy, input int ex, input int ey,
                           input int scx, input int scy);
    c_base[l] = base; c_shift[l] = sh; c_stride[l] = str; c_off[l] = off;
    c_sx[l] = sx; c_sy[l] = sy; c_ex[l] = ex; c_ey[l] = ey; c_scx[l] = scx; c_scy[l] = scy;
  endtask

  initial begin
    c_en = '0;
    for (int l = 0; l < NL; l++) set_layer(l, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dx = '0; dy = '0; frame_start = 1'b0; line_start = 1'b0; rst_pix = 1'b1;
    for (int i = 0; i < 3; i++) drive(XLO, 0, 1'b0, 1'b0, 1'b1);

    // Config present but no frame_start yet: both layers must stay dark
    c_en = 2'b11;
    set_layer(0, 'h100, 0, 4, 0, 0, 0, 4, 2, 0, 0);
    set_layer(1, 'h100, 0, 4, 0, 0, 0, 8, 4, 2, 2);
    run_line(0, 1'b0, NONE);
    run_line(1, 1'b0, NONE);

    // Unscaled 4x2 window on L0, 2x2 scaled 8x4 window on L1
    for (int y = 0; y < 5; y++) run_line(y, y == 0, NONE);

    // Scroll offset on L0; L1 near the top of the pixel address space with a negative x start
    set_layer(0, 0, 0, 8, 2, 0, 0, 4, 2, 1, 1);
    set_layer(1, 0, 0, 4, 'h1FFFFFF, -2, 0, 1, 1, 1, 1);
    for (int y = 0; y < 3; y++) run_line(y, y == 0, NONE);

    // Four pixels per word on L0; inverted (empty) window on L1
    set_layer(0, 'h40, 2, 8, 0, 0, 0, 8, 1, 1, 1);
    set_layer(1, 'h80, 0, 4, 0, 3, 1, 2, 3, 1, 1);
    for (int y = 0; y < 3; y++) run_line(y, y == 0, NONE);

    // Mid-frame base change and layer disable must wait for the next frame
    set_layer(0, 'h100, 0, 4, 0, 0, 0, 4, 2, 1, 1);
    set_layer(1, 'h300, 0, 4, 0, 2, 0, 6, 1, 1, 1);
    run_line(0, 1'b1, NONE);
    c_base[0] = 'h200;
    c_en = 2'b01;
    run_line(1, 1'b0, NONE);
    run_line(2, 1'b0, NONE);
    for (int y = 0; y < 3; y++) run_line(y, y == 0, NONE);

    // Overlapping windows on both layers, then reset in the middle of a line
    c_en = 2'b11;
    set_layer(0, 'h100, 0, 4, 0, 0, 0, 4, 1, 1, 1);
    run_line(0, 1'b1, NONE);
    run_line(0, 1'b1, 2);
    run_line(1, 1'b0, NONE);
    for (int y = 0; y < 2; y++) run_line(y, y == 0, NONE);
    for (int i = 0; i < 4; i++) drive(XLO, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
